catch_arbiter: RTL and testbench

Shared-item ownership controller for the two-player miner field. It watches per-item hook-tail contact from the left and right hooks and grants each item to at most one hook, breaking same-item conflicts with round-robin priority. It retires items on explosion or on delivery home, and accumulates per-player score. It sits between the hook/string logic and the per-item sprite blocks: it drives their hold and destroy flags and consumes their hit flags.

---
 rtl/catch_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_catch_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/catch_arbiter.sv
// catch_arbiter: grants field items to the left/right hook, resolves
// same-item conflicts round-robin, retires items on explosion or
// delivery, and keeps a saturating score for each player.
module catch_arbiter #(
  parameter int N_ITEMS = 8,
  parameter int VALUE_W = 8,
  parameter int SCORE_W = 16
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       is_new_game_start,
  input  logic [N_ITEMS-1:0]         hit_l,
  input  logic [N_ITEMS-1:0]         hit_r,
  input  logic                       hook_home_l,
  input  logic                       hook_home_r,
  input  logic                       is_explodel,
  input  logic                       is_exploder,
  input  logic [N_ITEMS*VALUE_W-1:0] item_value,
  output logic [N_ITEMS-1:0]         held_l,
  output logic [N_ITEMS-1:0]         held_r,
  output logic                       is_catchl,
  output logic                       is_catchr,
  output logic [N_ITEMS-1:0]         destroyed,
  output logic [SCORE_W-1:0]         score_l,
  output logic [SCORE_W-1:0]         score_r,
  output logic                       score_pulse_l,
  output logic                       score_pulse_r,
  output logic                       rr_pri
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} hook_st_e;

  hook_st_e               st_l_q, st_l_d, st_r_q, st_r_d;
  logic [3:0]             idx_l_q, idx_l_d, idx_r_q, idx_r_d;
  logic [N_ITEMS-1:0]     held_l_q, held_l_d, held_r_q, held_r_d;
  logic [N_ITEMS-1:0]     destroyed_q, destroyed_d;
  logic [SCORE_W-1:0]     score_l_q, score_l_d, score_r_q, score_r_d;
  logic                   pulse_l_q, pulse_l_d, pulse_r_q, pulse_r_d;
  logic                   rr_q, rr_d;

  logic [N_ITEMS-1:0]     free_items, cand_l, cand_r;
  logic                   fnd_l, fnd_r, conflict, grant_l, grant_r;
  logic [3:0]             sel_l, sel_r;

  // Lowest set index of a candidate vector, with a found flag in the MSB.
  function automatic logic [4:0] pick_lowest(input logic [N_ITEMS-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Score value of the slot addressed by idx.
  function automatic logic [VALUE_W-1:0] value_at(input logic [3:0] idx);
    logic [VALUE_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (idx == 4'(i)) v = item_value[i*VALUE_W +: VALUE_W];
    end
    return v;
  endfunction

  // Zero-extend, add with one carry bit, clamp to all-ones on overflow.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [VALUE_W-1:0] v);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W + 1)'(v);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Claim selection: only idle hooks away from the pivot compete for free items.
  always_comb begin
    free_items = ~destroyed_q & ~held_l_q & ~held_r_q;
    cand_l     = (st_l_q == IDLE && !hook_home_l) ? (hit_l & free_items) : '0;
    cand_r     = (st_r_q == IDLE && !hook_home_r) ? (hit_r & free_items) : '0;
    {fnd_l, sel_l} = pick_lowest(cand_l);
    {fnd_r, sel_r} = pick_lowest(cand_r);
    conflict   = fnd_l && fnd_r && (sel_l == sel_r);
    grant_l    = fnd_l && (!conflict || !rr_q);
    grant_r    = fnd_r && (!conflict ||  rr_q);
  end

  // Next-state for both hook FSMs, retirement, scoring and the sync clear.
  always_comb begin
    st_l_d      = st_l_q;
    st_r_d      = st_r_q;
    idx_l_d     = idx_l_q;
    idx_r_d     = idx_r_q;
    held_l_d    = held_l_q;
    held_r_d    = held_r_q;
    destroyed_d = destroyed_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    pulse_l_d   = 1'b0;
    pulse_r_d   = 1'b0;
    rr_d        = conflict ? ~rr_q : rr_q;

    if (st_l_q == IDLE) begin
      if (grant_l) begin
        st_l_d   = HOLD;
        idx_l_d  = sel_l;
        held_l_d = N_ITEMS'(1) << sel_l;
      end
    end else if (is_explodel || hook_home_l) begin
      // Explosion outranks delivery: the item is retired either way,
      // but only a delivery earns points.
      st_l_d      = IDLE;
      held_l_d    = '0;
      destroyed_d = destroyed_d | held_l_q;
      if (!is_explodel) begin
        score_l_d = sat_add(score_l_q, value_at(idx_l_q));
        pulse_l_d = 1'b1;
      end
    end

    if (st_r_q == IDLE) begin
      if (grant_r) begin
        st_r_d   = HOLD;
        idx_r_d  = sel_r;
        held_r_d = N_ITEMS'(1) << sel_r;
      end
    end else if (is_exploder || hook_home_r) begin
      st_r_d      = IDLE;
      held_r_d    = '0;
      destroyed_d = destroyed_d | held_r_q;
      if (!is_exploder) begin
        score_r_d = sat_add(score_r_q, value_at(idx_r_q));
        pulse_r_d = 1'b1;
      end
    end

    // A new game overrides everything, including a same-cycle delivery.
    if (is_new_game_start) begin
      st_l_d      = IDLE;
      st_r_d      = IDLE;
      idx_l_d     = '0;
      idx_r_d     = '0;
      held_l_d    = '0;
      held_r_d    = '0;
      destroyed_d = '0;
      score_l_d   = '0;
      score_r_d   = '0;
      pulse_l_d   = 1'b0;
      pulse_r_d   = 1'b0;
      rr_d        = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      st_l_q      <= IDLE;
      st_r_q      <= IDLE;
      idx_l_q     <= '0;
      idx_r_q     <= '0;
      held_l_q    <= '0;
      held_r_q    <= '0;
      destroyed_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      pulse_l_q   <= 1'b0;
      pulse_r_q   <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      st_l_q      <= st_l_d;
      st_r_q      <= st_r_d;
      idx_l_q     <= idx_l_d;
      idx_r_q     <= idx_r_d;
      held_l_q    <= held_l_d;
      held_r_q    <= held_r_d;
      destroyed_q <= destroyed_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      pulse_l_q   <= pulse_l_d;
      pulse_r_q   <= pulse_r_d;
      rr_q        <= rr_d;
    end
  end

  assign held_l        = held_l_q;
  assign held_r        = held_r_q;
  assign is_catchl     = |held_l_q;
  assign is_catchr     = |held_r_q;
  assign destroyed     = destroyed_q;
  assign score_l       = score_l_q;
  assign score_r       = score_r_q;
  assign score_pulse_l = pulse_l_q;
  assign score_pulse_r = pulse_r_q;
  assign rr_pri        = rr_q;

endmodule

// File: tb/tb_catch_arbiter.sv
// Scoreboard bench for catch_arbiter: each scenario task pushes the expected
// output image as it drives a stimulus row, then pops and compares it once
// the DUT has clocked that row.
module tb_catch_arbiter;

  localparam int N  = 8;
  localparam int VW = 16;
  localparam int SW = 16;

  logic            Clk = 1'b0;
  logic            reset;
  logic            is_new_game_start;
  logic [N-1:0]    hit_l, hit_r;
  logic            hook_home_l, hook_home_r;
  logic            is_explodel, is_exploder;
  logic [N*VW-1:0] item_value;
  logic [N-1:0]    held_l, held_r, destroyed;
  logic            is_catchl, is_catchr;
  logic [SW-1:0]   score_l, score_r;
  logic            score_pulse_l, score_pulse_r, rr_pri;

  // {ngs, ex_r, ex_l, home_r, home_l, hit_r, hit_l}
  typedef logic [20:0] stim_t;
  // {held_l, held_r, destroyed, score_l, score_r, pulse_l, pulse_r, rr, catch_l, catch_r}
  typedef logic [60:0] obs_t;

  obs_t exp_q[$];
  obs_t e;
  obs_t obs;
  int   vectors     = 0;
  int   miscompares = 0;

  assign obs = {held_l, held_r, destroyed, score_l, score_r,
                score_pulse_l, score_pulse_r, rr_pri, is_catchl, is_catchr};

  catch_arbiter #(.N_ITEMS(N), .VALUE_W(VW), .SCORE_W(SW)) dut (
    .Clk(Clk), .reset(reset), .is_new_game_start(is_new_game_start),
    .hit_l(hit_l), .hit_r(hit_r), .hook_home_l(hook_home_l), .hook_home_r(hook_home_r),
    .is_explodel(is_explodel), .is_exploder(is_exploder), .item_value(item_value),
    .held_l(held_l), .held_r(held_r), .is_catchl(is_catchl), .is_catchr(is_catchr),
    .destroyed(destroyed), .score_l(score_l), .score_r(score_r),
    .score_pulse_l(score_pulse_l), .score_pulse_r(score_pulse_r), .rr_pri(rr_pri)
  );

  always #5 Clk = ~Clk;

  function automatic stim_t st(input logic [7:0] hl, input logic [7:0] hr,
                               input logic hml, input logic hmr,
                               input logic exl, input logic exr, input logic ngs);
    return {ngs, exr, exl, hmr, hml, hr, hl};
  endfunction

  function automatic obs_t mk(input logic [7:0] hl, input logic [7:0] hr,
                              input logic [7:0] dst, input logic [15:0] sl,
                              input logic [15:0] sr, input logic pl,
                              input logic pr, input logic rr);
    return {hl, hr, dst, sl, sr, pl, pr, rr, |hl, |hr};
  endfunction

  task automatic drive(input stim_t s);
    {is_new_game_start, is_exploder, is_explodel, hook_home_r, hook_home_l, hit_r, hit_l} = s;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive('0);
    #2 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_async got %h want %h", obs, e);
    end
    step();
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_release got %h want %h", obs, e);
    end
  endtask

  task automatic test_single_claim();
    stim_t s[3];
    obs_t  x[3];
    s[0] = st(8'h08, 0, 0, 0, 0, 0, 0); x[0] = mk(8'h08, 0, 8'h08 & 8'h00, 0, 0, 0, 0, 0);
    s[1] = st(0, 0, 1, 0, 0, 0, 0);     x[1] = mk(0, 0, 8'h08, 25, 0, 1, 0, 0);
    s[2] = st(0, 0, 1, 0, 0, 0, 0);     x[2] = mk(0, 0, 8'h08, 25, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL single_claim[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_conflict();
    stim_t s[4];
    obs_t  x[4];
    s[0] = st(8'h01, 8'h01, 0, 0, 0, 0, 0); x[0] = mk(8'h01, 0, 8'h08, 25, 0, 0, 0, 1);
    s[1] = st(0, 0, 1, 0, 0, 0, 0);         x[1] = mk(0, 0, 8'h09, 35, 0, 1, 0, 1);
    s[2] = st(8'h02, 8'h02, 0, 0, 0, 0, 0); x[2] = mk(0, 8'h02, 8'h09, 35, 0, 0, 0, 0);
    s[3] = st(0, 0, 0, 1, 0, 0, 0);         x[3] = mk(0, 0, 8'h0B, 35, 7, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL conflict_rr[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_explode();
    stim_t s[5];
    obs_t  x[5];
    s[0] = st(8'h20, 0, 0, 0, 0, 0, 0); x[0] = mk(8'h20, 0, 8'h0B, 35, 7, 0, 0, 0);
    s[1] = st(0, 0, 1, 0, 1, 0, 0);     x[1] = mk(0, 0, 8'h2B, 35, 7, 0, 0, 0);
    s[2] = st(8'h04, 0, 0, 0, 0, 0, 0); x[2] = mk(8'h04, 0, 8'h2B, 35, 7, 0, 0, 0);
    s[3] = st(0, 0, 0, 0, 0, 1, 0);     x[3] = mk(8'h04, 0, 8'h2B, 35, 7, 0, 0, 0);
    s[4] = st(0, 0, 1, 0, 0, 0, 0);     x[4] = mk(0, 0, 8'h2F, 135, 7, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL explode[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_home_guard();
    stim_t s[3];
    obs_t  x[3];
    s[0] = st(0, 8'hFF, 0, 1, 0, 0, 0); x[0] = mk(0, 0, 8'h2F, 135, 7, 0, 0, 0);
    s[1] = st(0, 8'h30, 0, 0, 0, 0, 0); x[1] = mk(0, 8'h10, 8'h2F, 135, 7, 0, 0, 0);
    s[2] = st(0, 0, 0, 1, 0, 0, 0);     x[2] = mk(0, 0, 8'h3F, 135, 10, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL home_guard[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_clear_vs_delivery();
    stim_t s[3];
    obs_t  x[3];
    s[0] = st(8'h80, 8'h80, 0, 0, 0, 0, 0); x[0] = mk(8'h80, 0, 8'h3F, 135, 10, 0, 0, 1);
    s[1] = st(0, 0, 1, 0, 0, 0, 1);         x[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s[2] = st(0, 0, 0, 0, 0, 0, 0);         x[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL clear_vs_delivery[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s[5];
    obs_t  x[5];
    s[0] = st(8'h40, 0, 0, 0, 0, 0, 0); x[0] = mk(8'h40, 0, 0, 0, 0, 0, 0, 0);
    s[1] = st(0, 0, 1, 0, 0, 0, 0);     x[1] = mk(0, 0, 8'h40, 16'hFFF0, 0, 1, 0, 0);
    s[2] = st(8'h80, 0, 0, 0, 0, 0, 0); x[2] = mk(8'h80, 0, 8'h40, 16'hFFF0, 0, 0, 0, 0);
    s[3] = st(0, 0, 1, 0, 0, 0, 0);     x[3] = mk(0, 0, 8'hC0, 16'hFFFF, 0, 1, 0, 0);
    s[4] = st(0, 0, 0, 0, 0, 0, 1);     x[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL saturation[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(st(0, 8'h08, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 8'h08, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL async_claim got %h want %h", obs, e);
    end
    drive(st(0, 0, 0, 1, 0, 0, 0));
    #3 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL async_immediate got %h want %h", obs, e);
    end
    step();
    #2 reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL async_release got %h want %h", obs, e);
    end
    drive(st(0, 8'h08, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 8'h08, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL async_first_claim got %h want %h", obs, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive('0);
    item_value = '0;
    item_value[0*VW +: VW] = 16'd10;
    item_value[1*VW +: VW] = 16'd7;
    item_value[2*VW +: VW] = 16'd100;
    item_value[3*VW +: VW] = 16'd25;
    item_value[4*VW +: VW] = 16'd3;
    item_value[5*VW +: VW] = 16'd40;
    item_value[6*VW +: VW] = 16'hFFF0;
    item_value[7*VW +: VW] = 16'h0020;
    test_reset();
    test_single_claim();
    test_conflict();
    test_explode();
    test_home_guard();
    test_clear_vs_delivery();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
